// File: rtl/sr_ctrl_pkg.sv
// Shared types and default timing constants for the SR latch driver.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE_SET = 2'd1,
    PULSE_RST = 2'd2,
    GAP       = 2'd3
  } sr_drv_state_t;

  localparam int unsigned SyncStagesDflt     = 2;
  localparam int unsigned DebounceCyclesDflt = 16;
  localparam int unsigned PulseCyclesDflt    = 4;
  localparam int unsigned GapCyclesDflt      = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Synchroniser chain plus stable-level debouncer; emits a one-cycle pulse on each accepted rise.
module sr_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;

  // Flip on the cycle the counter would reach DEBOUNCE_CYCLES, so it never holds that value.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = synced;
        rise_d  = synced;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/reset button presses into fixed-width, mutually exclusive
// active-low pulses for an SR latch.
module sr_latch_driver
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SyncStagesDflt,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDflt,
  parameter int unsigned PULSE_CYCLES    = PulseCyclesDflt,
  parameter int unsigned GAP_CYCLES      = GapCyclesDflt
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn_i,
  input  logic reset_btn_i,
  output logic set_n_o,
  output logic reset_n_o,
  output logic busy_o,
  output logic conflict_o
);

  localparam int unsigned TimerW = $clog2(max_u(PULSE_CYCLES, GAP_CYCLES) + 1);

  logic set_rise, rst_rise;

  sr_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (set_btn_i),
    .rise_o(set_rise)
  );

  sr_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (reset_btn_i),
    .rise_o(rst_rise)
  );

  sr_drv_state_t     state_q, state_d;
  logic [TimerW-1:0] cnt_q, cnt_d;
  logic              set_pend_q, set_pend_d;
  logic              rst_pend_q, rst_pend_d;
  logic              conflict_q, conflict_d;
  logic              set_n_q, reset_n_q, busy_q;

  // A rise arriving in the same cycle a request is consumed stays pending.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    set_pend_d = set_pend_q | set_rise;
    rst_pend_d = rst_pend_q | rst_rise;
    conflict_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rst_pend_q) begin
          state_d    = PULSE_RST;
          rst_pend_d = rst_rise;
          if (set_pend_q) begin
            set_pend_d = set_rise;
            conflict_d = 1'b1;
          end
        end else if (set_pend_q) begin
          state_d    = PULSE_SET;
          set_pend_d = set_rise;
        end
      end
      PULSE_SET, PULSE_RST: begin
        if (cnt_q == TimerW'(PULSE_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TimerW'(1);
        end
      end
      GAP: begin
        if (cnt_q == TimerW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TimerW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      conflict_q <= 1'b0;
      set_n_q    <= 1'b1;
      reset_n_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      conflict_q <= conflict_d;
      set_n_q    <= (state_q != PULSE_SET);
      reset_n_q  <= (state_q != PULSE_RST);
      busy_q     <= (state_q != IDLE);
    end
  end

  assign set_n_o    = set_n_q;
  assign reset_n_o  = reset_n_q;
  assign busy_o     = busy_q;
  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: expected pulses queued at stimulus time, matched on output.
module tb_sr_latch_driver;

  localparam int SyncStages = 2;
  localparam int Debounce   = 4;
  localparam int Pulse      = 3;
  localparam int Gap        = 2;
  localparam int Lat        = SyncStages + Debounce + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_btn = 1'b0;
  logic reset_btn = 1'b0;
  logic set_n, reset_n, busy, conflict;

  sr_latch_driver #(
    .SYNC_STAGES    (SyncStages),
    .DEBOUNCE_CYCLES(Debounce),
    .PULSE_CYCLES   (Pulse),
    .GAP_CYCLES     (Gap)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_btn_i  (set_btn),
    .reset_btn_i(reset_btn),
    .set_n_o    (set_n),
    .reset_n_o  (reset_n),
    .busy_o     (busy),
    .conflict_o (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;     // 0 = set, 1 = reset
    int start;  // first edge after which the output is low
    int len;
  } pulse_t;

  pulse_t exp_q[$];
  int edge_n = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit set_lo = 1'b0;
  bit rst_lo = 1'b0;
  int set_start = 0;
  int rst_start = 0;
  int conf_cnt = 0;
  int conf_edge = -1;
  int base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic close_pulse(input int ch, input int start, input int len);
    pulse_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_pulse_start", start, -1);
    end else begin
      e = exp_q.pop_front();
      check("pulse_channel", ch, e.ch);
      check("pulse_start", start, e.start);
      check("pulse_len", len, e.len);
    end
  endtask

  // One clock: advance past the rising edge, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check("no_overlap", 32'(set_n | reset_n), 1);
    if (!set_n && !set_lo) begin
      set_lo = 1'b1;
      set_start = edge_n;
    end else if (set_n && set_lo) begin
      set_lo = 1'b0;
      close_pulse(0, set_start, edge_n - set_start);
    end
    if (!reset_n && !rst_lo) begin
      rst_lo = 1'b1;
      rst_start = edge_n;
    end else if (reset_n && rst_lo) begin
      rst_lo = 1'b0;
      close_pulse(1, rst_start, edge_n - rst_start);
    end
    if (conflict === 1'b1) begin
      conf_cnt++;
      conf_edge = edge_n;
    end
  endtask

  task automatic check_idle(input string tag);
    check(tag, 32'({set_n, reset_n, busy, conflict}), 32'(4'b1100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    check_idle("idle_in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle_after_reset");
    end

    // Single set press, exact latency and busy release
    set_btn = 1'b1;
    base = edge_n + 1;
    exp_q.push_back('{0, base + Lat, Pulse});
    while (edge_n < base + Lat + Pulse + Gap - 1) tick();
    check("busy_last_cycle", 32'(busy), 1);
    tick();
    check("busy_released", 32'(busy), 0);
    check("set_n_released", 32'(set_n), 1);
    set_btn = 1'b0;
    repeat (15) tick();
    check("drain_single", exp_q.size(), 0);

    // Bounce shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      set_btn = ~set_btn;
      repeat (2) begin
        tick();
        check("bounce_outputs_high", 32'({set_n, reset_n}), 32'(2'b11));
      end
    end
    set_btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bounce_quiet", 32'({set_n, reset_n, busy}), 32'(3'b110));
    end
    check("bounce_no_conflict", conf_cnt, 0);

    // Simultaneous presses: reset wins, set dropped
    conf_cnt = 0;
    set_btn = 1'b1;
    reset_btn = 1'b1;
    base = edge_n + 1;
    exp_q.push_back('{1, base + Lat, Pulse});
    while (edge_n < base + 20) tick();
    check("conflict_count", conf_cnt, 1);
    check("conflict_edge", conf_edge, base + Lat - 1);
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (15) tick();
    check("drain_conflict", exp_q.size(), 0);

    // Reset press debounced during a set pulse is served after the gap
    conf_cnt = 0;
    set_btn = 1'b1;
    base = edge_n + 1;
    exp_q.push_back('{0, base + Lat, Pulse});
    exp_q.push_back('{1, base + Lat + Pulse + Gap + 1, Pulse});
    repeat (2) tick();
    reset_btn = 1'b1;
    while (edge_n < base + 25) tick();
    check("drain_queued", exp_q.size(), 0);
    set_btn = 1'b0;
    reset_btn = 1'b0;
    repeat (15) tick();

    // Asynchronous reset in the middle of a set pulse
    set_btn = 1'b1;
    base = edge_n + 1;
    exp_q.push_back('{0, base + Lat, 2});
    while (edge_n < base + Lat + 1) tick();
    check("set_low_before_abort", 32'(set_n), 0);
    set_btn = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_set_n", 32'(set_n), 1);
    check("abort_reset_n", 32'(reset_n), 1);
    check("abort_busy", 32'(busy), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_idle("idle_after_abort");
    end
    check("drain_abort", exp_q.size(), 0);
    check("no_late_conflict", conf_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
